// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency 64-bit memory port between instruction fetch and data access.
module mem_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_done_o,
  output logic [31:0]       if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_done_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_f_o,
  output logic              stall_m_o
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;
  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              dm_own_q, dm_own_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_win;

  // fetch only beats a pending data request once it has lost STARVE_LIMIT times in a row
  assign if_win = if_req_i && (!dm_req_i || starve_q == SW'(STARVE_LIMIT));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    starve_d   = starve_q;
    dm_own_d   = dm_own_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    case (state_q)
      IDLE: if (if_req_i || dm_req_i) begin
        state_d  = ISSUE;
        dm_own_d = !if_win;
        we_d     = !if_win && dm_we_i;
        addr_d   = if_win ? if_addr_i : dm_addr_i;
        wdata_d  = dm_wdata_i;
        starve_d = if_win ? '0 :
                   (if_req_i && starve_q != SW'(STARVE_LIMIT)) ? starve_q + SW'(1) : starve_q;
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = CW'(MEM_LATENCY - 1);
      end
      WAIT: if (cnt_q == '0) begin
        state_d = RESP;
        if (dm_own_q) dm_rdata_d = mem_rdata_i;
        else          if_rdata_d = addr_q[2] ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      starve_q   <= '0;
      dm_own_q   <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      dm_own_q   <= dm_own_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign mem_req_o   = state_q == ISSUE;
  assign mem_we_o    = mem_req_o && we_q;
  assign mem_addr_o  = {addr_q[ADDR_W-1:3], 3'b000};
  assign mem_wdata_o = wdata_q;
  assign if_done_o   = state_q == RESP && !dm_own_q;
  assign dm_done_o   = state_q == RESP && dm_own_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign stall_f_o   = if_req_i && !if_done_o;
  assign stall_m_o   = dm_req_i && !dm_done_o;
endmodule
